// File: rtl/axi4_lite_buffer.sv
// axi4_lite_buffer: AXI4-Lite buffer, one FWFT FIFO per channel, with
// outstanding read/write limits. Optional stats ports: AXI4_LITE_BUFFER_STATS_EN.
// Ports: aclk, areset (async high); axi4_s_* upstream slave side (AR/AW/W in,
// R/B out); axi4_m_* downstream master side; rd_/wr_outstanding with macro.

module axi4_lite_buffer_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(D);

   logic [PW:0]  wptr;
   logic [PW:0]  rptr;
   logic [W-1:0] mem [D];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: nothing is presented until a push lands.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[PW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[PW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[PW] != rptr[PW]) &&
                  (wptr[PW-1:0] == rptr[PW-1:0]);
endmodule

module axi4_lite_buffer #(
   parameter int A       = 32,
   parameter int N       = 4,
   parameter int D       = 4,
   parameter int MAX_OUT = 8
) (
   input  logic                          aclk,
   input  logic                          areset,
`ifdef AXI4_LITE_BUFFER_STATS_EN
   output logic [$clog2(MAX_OUT+1)-1:0]  rd_outstanding,
   output logic [$clog2(MAX_OUT+1)-1:0]  wr_outstanding,
`endif
   input  logic                          axi4_s_arvalid,
   output logic                          axi4_s_arready,
   input  logic [A-1:0]                  axi4_s_araddr,
   input  logic                          axi4_s_awvalid,
   output logic                          axi4_s_awready,
   input  logic [A-1:0]                  axi4_s_awaddr,
   input  logic                          axi4_s_wvalid,
   output logic                          axi4_s_wready,
   input  logic [8*N-1:0]                axi4_s_wdata,
   input  logic [N-1:0]                  axi4_s_wstrb,
   output logic                          axi4_s_rvalid,
   input  logic                          axi4_s_rready,
   output logic [8*N-1:0]                axi4_s_rdata,
   output logic [1:0]                    axi4_s_rresp,
   output logic                          axi4_s_bvalid,
   input  logic                          axi4_s_bready,
   output logic [1:0]                    axi4_s_bresp,
   output logic                          axi4_m_arvalid,
   input  logic                          axi4_m_arready,
   output logic [A-1:0]                  axi4_m_araddr,
   output logic                          axi4_m_awvalid,
   input  logic                          axi4_m_awready,
   output logic [A-1:0]                  axi4_m_awaddr,
   output logic                          axi4_m_wvalid,
   input  logic                          axi4_m_wready,
   output logic [8*N-1:0]                axi4_m_wdata,
   output logic [N-1:0]                  axi4_m_wstrb,
   input  logic                          axi4_m_rvalid,
   output logic                          axi4_m_rready,
   input  logic [8*N-1:0]                axi4_m_rdata,
   input  logic [1:0]                    axi4_m_rresp,
   input  logic                          axi4_m_bvalid,
   output logic                          axi4_m_bready,
   input  logic [1:0]                    axi4_m_bresp
);
   localparam int                CW    = $clog2(MAX_OUT+1);
   localparam logic [CW-1:0]     MAX_C = CW'(MAX_OUT);
   localparam int                DW    = 8*N;

   logic ar_full, ar_empty, aw_full, aw_empty;
   logic w_full, w_empty, r_full, r_empty, b_full, b_empty;
   logic s_ar_hs, s_aw_hs, s_w_hs, s_r_hs, s_b_hs;
   logic m_ar_hs, m_aw_hs, m_w_hs, m_r_hs, m_b_hs;
   logic [CW-1:0]   rd_cnt;
   logic [CW-1:0]   wr_cnt;
   logic [DW+N-1:0] w_out;
   logic [DW+1:0]   r_out;

   // Readies are held low for the whole reset window.
   assign axi4_s_arready = ~areset & ~ar_full & (rd_cnt != MAX_C);
   assign axi4_s_awready = ~areset & ~aw_full & (wr_cnt != MAX_C);
   assign axi4_s_wready  = ~areset & ~w_full;
   assign axi4_m_rready  = ~areset & ~r_full;
   assign axi4_m_bready  = ~areset & ~b_full;

   assign axi4_m_arvalid = ~ar_empty;
   assign axi4_m_awvalid = ~aw_empty;
   assign axi4_m_wvalid  = ~w_empty;
   assign axi4_s_rvalid  = ~r_empty;
   assign axi4_s_bvalid  = ~b_empty;

   assign s_ar_hs = axi4_s_arvalid & axi4_s_arready;
   assign s_aw_hs = axi4_s_awvalid & axi4_s_awready;
   assign s_w_hs  = axi4_s_wvalid  & axi4_s_wready;
   assign s_r_hs  = axi4_s_rvalid  & axi4_s_rready;
   assign s_b_hs  = axi4_s_bvalid  & axi4_s_bready;
   assign m_ar_hs = axi4_m_arvalid & axi4_m_arready;
   assign m_aw_hs = axi4_m_awvalid & axi4_m_awready;
   assign m_w_hs  = axi4_m_wvalid  & axi4_m_wready;
   assign m_r_hs  = axi4_m_rvalid  & axi4_m_rready;
   assign m_b_hs  = axi4_m_bvalid  & axi4_m_bready;

   axi4_lite_buffer_fifo #(.W(A), .D(D)) u_ar (
      .clk(aclk), .rst(areset), .push(s_ar_hs), .pop(m_ar_hs),
      .wdata(axi4_s_araddr), .rdata(axi4_m_araddr),
      .full(ar_full), .empty(ar_empty)
   );

   axi4_lite_buffer_fifo #(.W(A), .D(D)) u_aw (
      .clk(aclk), .rst(areset), .push(s_aw_hs), .pop(m_aw_hs),
      .wdata(axi4_s_awaddr), .rdata(axi4_m_awaddr),
      .full(aw_full), .empty(aw_empty)
   );

   axi4_lite_buffer_fifo #(.W(DW+N), .D(D)) u_w (
      .clk(aclk), .rst(areset), .push(s_w_hs), .pop(m_w_hs),
      .wdata({axi4_s_wdata, axi4_s_wstrb}), .rdata(w_out),
      .full(w_full), .empty(w_empty)
   );
   assign {axi4_m_wdata, axi4_m_wstrb} = w_out;

   axi4_lite_buffer_fifo #(.W(DW+2), .D(D)) u_r (
      .clk(aclk), .rst(areset), .push(m_r_hs), .pop(s_r_hs),
      .wdata({axi4_m_rdata, axi4_m_rresp}), .rdata(r_out),
      .full(r_full), .empty(r_empty)
   );
   assign {axi4_s_rdata, axi4_s_rresp} = r_out;

   axi4_lite_buffer_fifo #(.W(2), .D(D)) u_b (
      .clk(aclk), .rst(areset), .push(m_b_hs), .pop(s_b_hs),
      .wdata(axi4_m_bresp), .rdata(axi4_s_bresp),
      .full(b_full), .empty(b_empty)
   );

   // Outstanding counts follow the upstream side only.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (s_ar_hs && !s_r_hs)      rd_cnt <= rd_cnt + 1'b1;
         else if (s_r_hs && !s_ar_hs) rd_cnt <= rd_cnt - 1'b1;
         if (s_aw_hs && !s_b_hs)      wr_cnt <= wr_cnt + 1'b1;
         else if (s_b_hs && !s_aw_hs) wr_cnt <= wr_cnt - 1'b1;
      end
   end

`ifdef AXI4_LITE_BUFFER_STATS_EN
   assign rd_outstanding = rd_cnt;
   assign wr_outstanding = wr_cnt;

   always_ff @(posedge aclk or posedge areset) begin
      if (!areset) begin
         if (s_r_hs && !s_ar_hs)  assert (rd_cnt != '0);
         if (s_ar_hs && !s_r_hs)  assert (rd_cnt != MAX_C);
         if (s_b_hs && !s_aw_hs)  assert (wr_cnt != '0);
         if (s_aw_hs && !s_b_hs)  assert (wr_cnt != MAX_C);
      end
   end
`endif
endmodule

// File: tb/tb_axi4_lite_buffer.sv
// tb_axi4_lite_buffer: random + directed bench for axi4_lite_buffer.
// Scoreboard queues per channel, occupancy/outstanding reference model.

module tb_axi4_lite_buffer;
   localparam int A       = 16;
   localparam int N       = 4;
   localparam int D       = 4;
   localparam int MAX_OUT = 2;
   localparam int DW      = 8*N;
   localparam int CW      = $clog2(MAX_OUT+1);

   logic aclk = 1'b0;
   logic areset;
   logic s_arvalid, s_arready, s_awvalid, s_awready;
   logic s_wvalid, s_wready, s_rvalid, s_rready, s_bvalid, s_bready;
   logic [A-1:0]  s_araddr, s_awaddr, m_araddr, m_awaddr;
   logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
   logic [N-1:0]  s_wstrb, m_wstrb;
   logic [1:0]    s_rresp, s_bresp, m_rresp, m_bresp;
   logic m_arvalid, m_arready, m_awvalid, m_awready;
   logic m_wvalid, m_wready, m_rvalid, m_rready, m_bvalid, m_bready;
`ifdef AXI4_LITE_BUFFER_STATS_EN
   logic [CW-1:0] rd_outstanding, wr_outstanding;
`endif

   always #5 aclk = ~aclk;

   axi4_lite_buffer #(.A(A), .N(N), .D(D), .MAX_OUT(MAX_OUT)) dut (
      .aclk(aclk), .areset(areset),
`ifdef AXI4_LITE_BUFFER_STATS_EN
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
`endif
      .axi4_s_arvalid(s_arvalid), .axi4_s_arready(s_arready),
      .axi4_s_araddr(s_araddr),
      .axi4_s_awvalid(s_awvalid), .axi4_s_awready(s_awready),
      .axi4_s_awaddr(s_awaddr),
      .axi4_s_wvalid(s_wvalid), .axi4_s_wready(s_wready),
      .axi4_s_wdata(s_wdata), .axi4_s_wstrb(s_wstrb),
      .axi4_s_rvalid(s_rvalid), .axi4_s_rready(s_rready),
      .axi4_s_rdata(s_rdata), .axi4_s_rresp(s_rresp),
      .axi4_s_bvalid(s_bvalid), .axi4_s_bready(s_bready),
      .axi4_s_bresp(s_bresp),
      .axi4_m_arvalid(m_arvalid), .axi4_m_arready(m_arready),
      .axi4_m_araddr(m_araddr),
      .axi4_m_awvalid(m_awvalid), .axi4_m_awready(m_awready),
      .axi4_m_awaddr(m_awaddr),
      .axi4_m_wvalid(m_wvalid), .axi4_m_wready(m_wready),
      .axi4_m_wdata(m_wdata), .axi4_m_wstrb(m_wstrb),
      .axi4_m_rvalid(m_rvalid), .axi4_m_rready(m_rready),
      .axi4_m_rdata(m_rdata), .axi4_m_rresp(m_rresp),
      .axi4_m_bvalid(m_bvalid), .axi4_m_bready(m_bready),
      .axi4_m_bresp(m_bresp)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: each channel is an ordered queue bounded by D.
   logic [A-1:0]    q_ar[$];
   logic [A-1:0]    q_aw[$];
   logic [DW+N-1:0] q_w[$];
   logic [DW+1:0]   q_r[$];
   logic [1:0]      q_b[$];
   int rd_m = 0, wr_m = 0;
   int m_ar_cnt = 0, m_aw_cnt = 0;

   initial begin : monitor
      logic e_arv, e_awv, e_wv, e_rv, e_bv;
      logic e_arr, e_awr, e_wr, e_rr, e_br;
      logic h_sar, h_saw, h_sw, h_mr, h_mb;
      logic h_mar, h_maw, h_mw, h_sr, h_sb;
      logic [DW+N-1:0] wexp;
      logic [DW+1:0]   rexp;
      forever begin
         @(negedge aclk);
         if (areset) begin
            check("rst_valids",
                  {m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid}, 0);
            check("rst_readies",
                  {s_arready, s_awready, s_wready, m_rready, m_bready}, 0);
`ifdef AXI4_LITE_BUFFER_STATS_EN
            check("rst_outstanding", {rd_outstanding, wr_outstanding}, 0);
`endif
            q_ar.delete(); q_aw.delete(); q_w.delete();
            q_r.delete();  q_b.delete();
            rd_m = 0; wr_m = 0;
         end else begin
            e_arv = q_ar.size() > 0;
            e_awv = q_aw.size() > 0;
            e_wv  = q_w.size() > 0;
            e_rv  = q_r.size() > 0;
            e_bv  = q_b.size() > 0;
            e_arr = q_ar.size() < D && rd_m < MAX_OUT;
            e_awr = q_aw.size() < D && wr_m < MAX_OUT;
            e_wr  = q_w.size() < D;
            e_rr  = q_r.size() < D;
            e_br  = q_b.size() < D;
            check("valids", {m_arvalid, m_awvalid, m_wvalid, s_rvalid,
                  s_bvalid}, {e_arv, e_awv, e_wv, e_rv, e_bv});
            check("readies", {s_arready, s_awready, s_wready, m_rready,
                  m_bready}, {e_arr, e_awr, e_wr, e_rr, e_br});
`ifdef AXI4_LITE_BUFFER_STATS_EN
            check("rd_outstanding", rd_outstanding, rd_m);
            check("wr_outstanding", wr_outstanding, wr_m);
`endif
            h_sar = s_arvalid && e_arr;
            h_saw = s_awvalid && e_awr;
            h_sw  = s_wvalid && e_wr;
            h_mr  = m_rvalid && e_rr;
            h_mb  = m_bvalid && e_br;
            h_mar = e_arv && m_arready;
            h_maw = e_awv && m_awready;
            h_mw  = e_wv && m_wready;
            h_sr  = e_rv && s_rready;
            h_sb  = e_bv && s_bready;
            if (h_mar) begin
               check("m_araddr", m_araddr, q_ar.pop_front());
               m_ar_cnt++;
            end
            if (h_maw) begin
               check("m_awaddr", m_awaddr, q_aw.pop_front());
               m_aw_cnt++;
            end
            if (h_mw) begin
               wexp = q_w.pop_front();
               check("m_wdata_strb", {m_wdata, m_wstrb}, wexp);
            end
            if (h_sr) begin
               rexp = q_r.pop_front();
               check("s_rdata_resp", {s_rdata, s_rresp}, rexp);
            end
            if (h_sb) check("s_bresp", s_bresp, q_b.pop_front());
            if (h_sar) q_ar.push_back(s_araddr);
            if (h_saw) q_aw.push_back(s_awaddr);
            if (h_sw)  q_w.push_back({s_wdata, s_wstrb});
            if (h_mr)  q_r.push_back({m_rdata, m_rresp});
            if (h_mb)  q_b.push_back(m_bresp);
            rd_m = rd_m + int'(h_sar) - int'(h_sr);
            wr_m = wr_m + int'(h_saw) - int'(h_sb);
         end
      end
   end

   function automatic logic rdy(input int ch);
      case (ch)
         0: return s_arready;
         1: return s_awready;
         2: return s_wready;
         3: return m_rready;
         4: return m_bready;
         default: return 1'b0;
      endcase
   endfunction

   // Called at posedge+1 with valid raised; returns at posedge+1 after
   // the handshake edge.
   task automatic wait_rdy(input int ch, input string nm);
      int t = 0;
      @(negedge aclk);
      while (!rdy(ch) && t < 500) begin
         @(negedge aclk);
         t++;
      end
      if (!rdy(ch)) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s: ready 0 expected 1 within 500 cycles", nm);
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic up_ar(input logic [A-1:0] a);
      s_arvalid = 1; s_araddr = a;
      wait_rdy(0, "arready");
      s_arvalid = 0;
   endtask

   task automatic up_aw(input logic [A-1:0] a);
      s_awvalid = 1; s_awaddr = a;
      wait_rdy(1, "awready");
      s_awvalid = 0;
   endtask

   task automatic up_w(input logic [DW-1:0] d, input logic [N-1:0] s);
      s_wvalid = 1; s_wdata = d; s_wstrb = s;
      wait_rdy(2, "wready");
      s_wvalid = 0;
   endtask

   task automatic dn_r(input logic [DW-1:0] d, input logic [1:0] r);
      m_rvalid = 1; m_rdata = d; m_rresp = r;
      wait_rdy(3, "rready");
      m_rvalid = 0;
   endtask

   task automatic dn_b(input logic [1:0] r);
      m_bvalid = 1; m_bresp = r;
      wait_rdy(4, "bready");
      m_bvalid = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   logic rand_done;
   int base_ar, base_aw;

   initial begin
      areset = 1;
      s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
      s_araddr = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
      s_rready = 0; s_bready = 0;
      m_arready = 0; m_awready = 0; m_wready = 0;
      m_rvalid = 0; m_bvalid = 0; m_rdata = 0; m_rresp = 0; m_bresp = 0;
      rand_done = 0;
      cyc(3);
      areset = 0;
      @(negedge aclk);
      check("post_rst_ready", {s_arready, s_awready, s_wready}, 3'b111);
      check("post_rst_valid", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
      @(posedge aclk); #1;

      // Read stream against the outstanding limit.
      m_arready = 1; s_rready = 1;
      fork
         for (int i = 0; i < 4; i++) up_ar(A'(32'h100 + i));
         begin
            cyc(6);
            @(negedge aclk);
            check("arready_at_limit", s_arready, 0);
`ifdef AXI4_LITE_BUFFER_STATS_EN
            check("rd_out_at_limit", rd_outstanding, 2);
`endif
            @(posedge aclk); #1;
            dn_r(32'hA0, 2'b00);
            @(negedge aclk);
            @(negedge aclk);
            check("arready_after_r", s_arready, 1);
            @(posedge aclk); #1;
            for (int i = 1; i < 4; i++) begin
               cyc(3);
               dn_r(DW'(32'hA0 + i), 2'b01);
            end
         end
      join
      cyc(5);

      // Fill the W FIFO, then drain it in one burst.
      m_wready = 0;
      for (int i = 1; i <= 4; i++) up_w(DW'(32'h11 * i), 4'hF);
      @(negedge aclk);
      check("wready_full", s_wready, 0);
      @(posedge aclk); #1;
      m_wready = 1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge aclk);
         check("w_burst_valid", m_wvalid, 1);
         check("w_burst_data", m_wdata, 32'h11 * i);
      end
      @(negedge aclk);
      check("w_burst_end", m_wvalid, 0);
      @(posedge aclk); #1;

      // AW accept and B return on the same edge.
      m_awready = 1; s_bready = 0;
      up_aw(16'h200);
      dn_b(2'b10);
      @(negedge aclk);
      check("bresp_pass", s_bresp, 2'b10);
      @(posedge aclk); #1;
      s_bready = 1;
      up_aw(16'h204);
`ifdef AXI4_LITE_BUFFER_STATS_EN
      @(negedge aclk);
      check("wr_out_simul", wr_outstanding, 1);
      @(posedge aclk); #1;
`endif
      dn_b(2'b00);
      cyc(4);

      // Pointer wrap on R with random upstream back-pressure.
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               up_ar(A'(32'h400 + i));
               dn_r(DW'(i), 2'(i));
            end
            rand_done = 1;
         end
         while (!rand_done) begin
            @(posedge aclk); #1;
            s_rready = 1'($urandom_range(0, 1));
         end
      join
      s_rready = 1;
      rand_done = 0;
      cyc(6);

      // Reset while the AR FIFO holds entries.
      m_arready = 0;
      up_ar(16'h300);
      up_ar(16'h304);
      @(negedge aclk);
      check("ar_held", m_arvalid, 1);
      @(posedge aclk); #1;
      areset = 1;
      #1 check("arvalid_async_rst", m_arvalid, 0);
      cyc(2);
      areset = 0;
      m_arready = 1;
      repeat (4) begin
         @(negedge aclk);
         check("no_stale_ar", m_arvalid, 0);
      end
      @(posedge aclk); #1;
      up_ar(16'h308);
      cyc(2);
      dn_r(32'h308, 2'b00);
      cyc(4);

      // Random traffic on all channels.
      base_ar = m_ar_cnt;
      base_aw = m_aw_cnt;
      fork
         begin
            fork
               for (int i = 0; i < 40; i++) begin
                  cyc($urandom_range(0, 2));
                  up_ar(A'($urandom));
               end
               for (int i = 0; i < 40; i++) begin
                  cyc($urandom_range(0, 2));
                  up_aw(A'($urandom));
               end
               for (int i = 0; i < 40; i++) begin
                  cyc($urandom_range(0, 2));
                  up_w(DW'($urandom), N'($urandom));
               end
               begin
                  int sent = 0;
                  int g = 0;
                  while (sent < 40 && g < 5000) begin
                     if (m_ar_cnt - base_ar > sent && $urandom_range(0, 3) != 0) begin
                        dn_r(DW'($urandom), 2'($urandom));
                        sent++;
                     end else cyc(1);
                     g++;
                  end
                  check("r_all_sent", sent, 40);
               end
               begin
                  int sent = 0;
                  int g = 0;
                  while (sent < 40 && g < 5000) begin
                     if (m_aw_cnt - base_aw > sent && $urandom_range(0, 3) != 0) begin
                        dn_b(2'($urandom));
                        sent++;
                     end else cyc(1);
                     g++;
                  end
                  check("b_all_sent", sent, 40);
               end
            join
            rand_done = 1;
         end
         while (!rand_done) begin
            @(posedge aclk); #1;
            m_arready = $urandom_range(0, 3) != 0;
            m_awready = $urandom_range(0, 3) != 0;
            m_wready  = $urandom_range(0, 3) != 0;
            s_rready  = $urandom_range(0, 3) != 0;
            s_bready  = $urandom_range(0, 3) != 0;
         end
      join
      m_arready = 1; m_awready = 1; m_wready = 1;
      s_rready = 1; s_bready = 1;
      cyc(20);
      @(negedge aclk);
      check("drain_ar", q_ar.size(), 0);
      check("drain_aw", q_aw.size(), 0);
      check("drain_w", q_w.size(), 0);
      check("drain_r", q_r.size(), 0);
      check("drain_b", q_b.size(), 0);
      check("drain_valids", {m_arvalid, m_awvalid, m_wvalid, s_rvalid,
            s_bvalid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
